// File: rtl/msm_ram_pkg.sv
// Shared constants and helpers for the MSM RAM-backed staging queues.
// Read latency and prefetch depth derive from the FLOPOUT setting of the RAM.
package msm_ram_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Cycles from read issue to data on the RAM output.
    function automatic int rd_lat(input int flopout);
        return 1 + flopout;
    endfunction

    // One slot per in-flight read plus one being consumed keeps a streaming reader fed.
    function automatic int pf_depth(input int flopout);
        return rd_lat(flopout) + 1;
    endfunction

    // RAM occupancy counter width (holds 0..NWORDS).
    function automatic int cnt_w(input int addrsz);
        return addrsz + 1;
    endfunction

endpackage

// File: rtl/ram_fifo_1r1w_if.sv
// Valid/ready handshake bundle for ram_fifo_1r1w.
// Optional level/afull signals exist only when RAM_FIFO_LEVEL_EN is defined.
interface ram_fifo_1r1w_if #(
    parameter int WORDSZ = 32,
    parameter int ADDRSZ = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [WORDSZ-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORDSZ-1:0] out_data;
`ifdef RAM_FIFO_LEVEL_EN
    logic [ADDRSZ+1:0] level;
    logic              afull;
`endif

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
`ifdef RAM_FIFO_LEVEL_EN
        , input level, afull
`endif
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
`ifdef RAM_FIFO_LEVEL_EN
        , output level, afull
`endif
    );
endinterface

// File: rtl/ram_fifo_1r1w_pf.sv
// Prefetch buffer in front of the RAM read port. Tracks in-flight reads with a
// RD_LAT-deep valid pipe and grants read credit so buffered + in-flight words
// never exceed PF_DEPTH; a same-cycle pop frees a slot for back-to-back streaming.
module ram_fifo_pf
    import msm_ram_pkg::*;
#(
    parameter int WORDSZ   = 32,
    parameter int RD_LAT   = 1,
    parameter int PF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd_issue,
    input  logic [WORDSZ-1:0] rd_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORDSZ-1:0] out_data,
    output logic              pop,
    output logic              credit
);
    localparam int CW = clog2(PF_DEPTH + 1);
    localparam int IW = clog2(PF_DEPTH);

    logic [RD_LAT-1:0] vld_pipe;
    logic [CW-1:0]     pf_cnt, inflight;
    logic [IW-1:0]     head, tail;
    logic [WORDSZ-1:0] buf_q [PF_DEPTH];
    logic              ret;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == IW'(PF_DEPTH - 1)) ? '0 : i + 1'b1;
    endfunction

    assign ret       = vld_pipe[RD_LAT-1];
    assign out_valid = (pf_cnt != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = buf_q[head];
    assign credit    = ({1'b0, pf_cnt} + {1'b0, inflight}) <
                       ((CW+1)'(PF_DEPTH) + (CW+1)'(pop));

    // valid pipe, occupancy and ring indices; reset drops in-flight returns
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_pipe <= '0;
            inflight <= '0;
            pf_cnt   <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            vld_pipe <= (vld_pipe << 1) | RD_LAT'(rd_issue);
            inflight <= inflight + CW'(rd_issue) - CW'(ret);
            pf_cnt   <= pf_cnt + CW'(ret) - CW'(pop);
            if (ret) tail <= nxt(tail);
            if (pop) head <= nxt(head);
        end
    end

    // capture returning RAM word at the tail
    always_ff @(posedge clk) begin
        if (ret) buf_q[tail] <= rd_data;
    end
endmodule

// File: rtl/ram_mdl_1r1w.sv
// Simple-dual-port RAM model: one write port with bit mask, one registered read
// port, optional extra output register (FLOPOUT) giving read latency 1+FLOPOUT.
module ram_mdl_1r1w #(
    parameter int    DEPTH     = 1024,
    parameter int    WIDTH     = 32,
    parameter int    AW        = 10,
    parameter string RAM_STYLE = "block",
    parameter int    FLOPOUT   = 0
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] wem,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // masked write
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= (mem[waddr] & ~wem) | (wdata & wem);
    end

    if (RAM_STYLE == "distributed") begin : g_lut
        // LUT RAM: asynchronous array read captured in a fabric register
        logic [WIDTH-1:0] rd_async;
        assign rd_async = mem[raddr];
        // capture read word on enable
        always_ff @(posedge clk) begin
            if (re) rd_q <= rd_async;
        end
    end else begin : g_blk
        // block RAM: synchronous read port
        always_ff @(posedge clk) begin
            if (re) rd_q <= mem[raddr];
        end
    end

    if (FLOPOUT != 0) begin : g_flop
        logic [WIDTH-1:0] rd_q2;
        // extra output stage for timing closure
        always_ff @(posedge clk) begin
            rd_q2 <= rd_q;
        end
        assign rdata = rd_q2;
    end else begin : g_noflop
        assign rdata = rd_q;
    end
endmodule

// File: rtl/ram_fifo_1r1w.sv
// FWFT FIFO on a single simple-dual-port RAM with a prefetch buffer hiding the
// RAM read latency. Optional feature macro: RAM_FIFO_LEVEL_EN adds registered
// level and afull outputs.
module ram_fifo_1r1w
    import msm_ram_pkg::*;
#(
    parameter int    NWORDS         = 1024,
    parameter int    WORDSZ         = 32,
    parameter int    ADDRSZ         = 10,
    parameter string FPGA_RAM_STYLE = "block",
    parameter int    FLOPOUT        = 0,
    parameter int    AFULL_THR      = NWORDS - 8
) (
    input logic            clk,
    input logic            rstn,
    ram_fifo_1r1w_if.slave bus
);
    localparam int RD_LAT   = rd_lat(FLOPOUT);
    localparam int PF_DEPTH = pf_depth(FLOPOUT);
    localparam int CNTW     = cnt_w(ADDRSZ);

    logic [ADDRSZ-1:0] wptr, rptr;
    logic [CNTW-1:0]   ram_cnt, ram_cnt_nxt;
    logic              in_ready_q;
    logic              push, pop, rd_issue, pf_credit;
    logic [WORDSZ-1:0] rd_data;

    // in_ready comes only from registered state
    assign push         = bus.in_valid & in_ready_q;
    assign rd_issue     = (ram_cnt != '0) & pf_credit;
    assign bus.in_ready = in_ready_q;

    // RAM occupancy after this cycle's write and read issue
    always_comb begin
        ram_cnt_nxt = ram_cnt + CNTW'(push) - CNTW'(rd_issue);
    end

    // pointers and RAM occupancy; in_ready reopens a cycle after space frees
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr       <= '0;
            rptr       <= '0;
            ram_cnt    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (push)     wptr <= wptr + 1'b1;
            if (rd_issue) rptr <= rptr + 1'b1;
            ram_cnt    <= ram_cnt_nxt;
            in_ready_q <= (ram_cnt_nxt != CNTW'(NWORDS));
        end
    end

    ram_mdl_1r1w #(
        .DEPTH     (NWORDS),
        .WIDTH     (WORDSZ),
        .AW        (ADDRSZ),
        .RAM_STYLE (FPGA_RAM_STYLE),
        .FLOPOUT   (FLOPOUT)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (bus.in_data),
        .wem   ({WORDSZ{1'b1}}),
        .re    (rd_issue),
        .raddr (rptr),
        .rdata (rd_data)
    );

    ram_fifo_pf #(
        .WORDSZ   (WORDSZ),
        .RD_LAT   (RD_LAT),
        .PF_DEPTH (PF_DEPTH)
    ) u_pf (
        .clk       (clk),
        .rstn      (rstn),
        .rd_issue  (rd_issue),
        .rd_data   (rd_data),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .pop       (pop),
        .credit    (pf_credit)
    );

`ifdef RAM_FIFO_LEVEL_EN
    localparam int LW = ADDRSZ + 2;
    logic [LW-1:0] level_q, level_nxt;
    logic          afull_q;

    // words move RAM -> in-flight -> prefetch without changing the total,
    // so ram_cnt + inflight + pf_cnt tracks push minus pop
    always_comb begin
        level_nxt = level_q + LW'(push) - LW'(pop);
    end

    // registered level and almost-full flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            level_q <= '0;
            afull_q <= 1'b0;
        end else begin
            level_q <= level_nxt;
            afull_q <= (level_nxt >= LW'(AFULL_THR));
        end
    end

    assign bus.level = level_q;
    assign bus.afull = afull_q;
`endif
endmodule
